// File: rtl/plab5_mcore_mem_arbiter.sv
// Two-requester memory arbiter: round-robin or domain-priority grant, one transaction outstanding.
// Latency: memreq issues one cycle after a request is seen in IDLE; one idle cycle between transactions.
// Backpressure: the grant is held in REQ until memreq_rdy; the response waits on the owner's resp rdy.
// Optional PLAB5_MCORE_MEM_ARB_TIMEOUT_EN adds an 8-bit WAIT watchdog and the timeout_err output.

`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_, a_, d_) (3 + (o_) + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_, d_) (3 + (o_) + 2 + $clog2((d_) / 8) + (d_))
`endif

module plab5_mcore_mem_arbiter #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    localparam int rq = `VC_MEM_REQ_MSG_NBITS(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
    localparam int rs = `VC_MEM_RESP_MSG_NBITS(p_mem_opaque_nbits, p_mem_data_nbits)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic [rq-1:0] req0_msg,
    input  logic [rq-1:0] req1_msg,
    input  logic          req0_val,
    input  logic          req1_val,
    output logic          req0_rdy,
    output logic          req1_rdy,
    input  logic          req0_domain,
    input  logic          req1_domain,
    output logic [rq-1:0] memreq_msg,
    output logic          memreq_val,
    input  logic          memreq_rdy,
    output logic          memreq_domain,
    input  logic [rs-1:0] memresp_msg,
    input  logic          memresp_val,
    output logic          memresp_rdy,
    output logic [rs-1:0] resp0_msg,
    output logic [rs-1:0] resp1_msg,
    output logic          resp0_val,
    output logic          resp1_val,
    input  logic          resp0_rdy,
    input  logic          resp1_rdy,
    output logic          resp0_domain,
    output logic          resp1_domain
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_ptr;
    logic   r_dom;

    logic   w_win;
    logic   w_in_req;
    logic   w_in_wait;
    logic   w_owner_resp_rdy;
    logic   w_resp_hs;

`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_timeout;
`endif

    // Winner selection: a lone requester wins; in mode 1 a secure requester beats a non-secure one; ties go to the pointer.
    always_comb begin
        w_win = r_ptr;
        if (req0_val && !req1_val) begin
            w_win = 1'b0;
        end else if (req1_val && !req0_val) begin
            w_win = 1'b1;
        end else if (mode && (req0_domain != req1_domain)) begin
            w_win = req1_domain;
        end
    end

    // Reset masks every handshake output so an abandoned transaction never completes on the reset cycle.
    assign w_in_req         = (r_state == ST_REQ) && !reset;
    assign w_in_wait        = (r_state == ST_WAIT) && !reset;
    assign w_owner_resp_rdy = r_owner ? resp1_rdy : resp0_rdy;
    assign w_resp_hs        = w_in_wait && memresp_val && w_owner_resp_rdy;

`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
    assign w_timeout   = w_in_wait && !w_resp_hs && (r_cnt == 8'hFF);
    assign timeout_err = w_timeout;
    // In IDLE a late response from a timed-out transaction is swallowed.
    assign memresp_rdy = (w_in_wait && w_owner_resp_rdy) || ((r_state == ST_IDLE) && !reset);
`else
    assign memresp_rdy = w_in_wait && w_owner_resp_rdy;
`endif

    assign memreq_val    = w_in_req;
    assign memreq_msg    = r_owner ? req1_msg : req0_msg;
    assign memreq_domain = (r_state == ST_REQ) ? r_dom : 1'b0;
    assign req0_rdy      = w_in_req && !r_owner && memreq_rdy;
    assign req1_rdy      = w_in_req &&  r_owner && memreq_rdy;

    assign resp0_msg     = memresp_msg;
    assign resp1_msg     = memresp_msg;
    assign resp0_val     = w_in_wait && !r_owner && memresp_val;
    assign resp1_val     = w_in_wait &&  r_owner && memresp_val;
    assign resp0_domain  = (r_state == ST_WAIT) ? r_dom : 1'b0;
    assign resp1_domain  = (r_state == ST_WAIT) ? r_dom : 1'b0;

    // Transaction FSM: owner and its domain are captured once at grant and held until the response (or timeout).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_dom   <= 1'b0;
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_val || req1_val) begin
                        r_state <= ST_REQ;
                        r_owner <= w_win;
                        r_dom   <= w_win ? req1_domain : req0_domain;
                    end
                end
                ST_REQ: begin
                    if (memreq_rdy) begin
                        r_state <= ST_WAIT;
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
                        r_cnt   <= 8'd0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_resp_hs) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= ~r_owner;
                    end
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= ~r_owner;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plab5_mcore_mem_arbiter.sv
// Bench for plab5_mcore_mem_arbiter: directed scenarios then randomized transactions.
// Expected grants come from a transaction-level model of the arbitration rules.
// Covers reset, round-robin, domain priority, backpressure, reset abort and (if enabled) timeout.

module tb_plab5_mcore_mem_arbiter;

    localparam int RQ = 3 + 8 + 32 + 2 + 32;
    localparam int RS = 3 + 8 + 2 + 2 + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [RQ-1:0] req0_msg, req1_msg;
    logic          req0_val, req1_val;
    logic          req0_rdy, req1_rdy;
    logic          req0_domain, req1_domain;
    logic [RQ-1:0] memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    logic          memreq_domain;
    logic [RS-1:0] memresp_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    logic [RS-1:0] resp0_msg, resp1_msg;
    logic          resp0_val, resp1_val;
    logic          resp0_rdy, resp1_rdy;
    logic          resp0_domain, resp1_domain;
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
    logic          timeout_err;
    localparam logic IDLE_RESP_RDY = 1'b1;
`else
    localparam logic IDLE_RESP_RDY = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic m_ptr;

    plab5_mcore_mem_arbiter dut (
        .clk(clk), .reset(reset), .mode(mode),
        .req0_msg(req0_msg), .req1_msg(req1_msg),
        .req0_val(req0_val), .req1_val(req1_val),
        .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
        .req0_domain(req0_domain), .req1_domain(req1_domain),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val),
        .memreq_rdy(memreq_rdy), .memreq_domain(memreq_domain),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val),
        .memresp_rdy(memresp_rdy),
        .resp0_msg(resp0_msg), .resp1_msg(resp1_msg),
        .resp0_val(resp0_val), .resp1_val(resp1_val),
        .resp0_rdy(resp0_rdy), .resp1_rdy(resp1_rdy),
        .resp0_domain(resp0_domain), .resp1_domain(resp1_domain)
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RQ-1:0] rnd_rq();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[RQ-1:0];
    endfunction

    function automatic logic [RS-1:0] rnd_rs();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[RS-1:0];
    endfunction

    // Arbitration rule: lone requester wins; mode 1 prefers the secure one; otherwise the pointer decides.
    function automatic logic model_win(logic md, logic v0, logic v1, logic d0, logic d1, logic ptr);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        if (md && (d0 != d1)) return d1;
        return ptr;
    endfunction

    // kind: 0 = complete transaction, 1 = reset while response pending, 2 = let it time out.
    task automatic do_txn(input logic md, input logic v0, input logic v1, input logic d0, input logic d1,
                          input int stall, input int rdly, input int rstall, input int kind);
        logic          w, edom;
        logic [RQ-1:0] emsg;
        logic [RS-1:0] rmsg;
        mode = md; req0_val = v0; req1_val = v1; req0_domain = d0; req1_domain = d1;
        req0_msg = rnd_rq(); req1_msg = rnd_rq();
        memreq_rdy = 1'b0; memresp_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        w = model_win(md, v0, v1, d0, d1, m_ptr);
        emsg = w ? req1_msg : req0_msg;
        edom = w ? d1 : d0;
        #1;
        chk("idle_memreq_val", 128'(memreq_val), 128'(0));
        chk("idle_req_rdy", 128'({req0_rdy, req1_rdy}), 128'(0));
        chk("idle_resp_val", 128'({resp0_val, resp1_val}), 128'(0));
        chk("idle_memresp_rdy", 128'(memresp_rdy), 128'(IDLE_RESP_RDY));
        tick();
        // REQ with backpressure: the other requester asserts val, domains wander.
        for (int s = 0; s < stall; s++) begin
            if (w) req0_val = 1'b1; else req1_val = 1'b1;
            req0_domain = 1'($urandom); req1_domain = 1'($urandom);
            #1;
            chk("req_val", 128'(memreq_val), 128'(1));
            chk("req_msg", 128'(memreq_msg), 128'(emsg));
            chk("req_dom", 128'(memreq_domain), 128'(edom));
            chk("req_rdy_stall", 128'({req1_rdy, req0_rdy}), 128'(0));
            tick();
        end
        memreq_rdy = 1'b1;
        #1;
        chk("req_val_hs", 128'(memreq_val), 128'(1));
        chk("req_msg_hs", 128'(memreq_msg), 128'(emsg));
        chk("req_dom_hs", 128'(memreq_domain), 128'(edom));
        chk("req_rdy_hs", 128'({req1_rdy, req0_rdy}), 128'(w ? 2'b10 : 2'b01));
        tick();
        memreq_rdy = 1'b0;
        // WAIT before the response shows up.
        for (int s = 0; s < rdly; s++) begin
            resp0_rdy = 1'($urandom); resp1_rdy = 1'($urandom);
            #1;
            chk("wait_memreq_val", 128'(memreq_val), 128'(0));
            chk("wait_resp_val", 128'({resp1_val, resp0_val}), 128'(0));
            chk("wait_resp_dom", 128'({resp1_domain, resp0_domain}), 128'({edom, edom}));
            tick();
        end
        rmsg = rnd_rs();
        if (kind == 1) begin
            memresp_msg = rmsg; memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
            reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0;
            #1;
            chk("rst_resp_val", 128'({resp1_val, resp0_val}), 128'(0));
            chk("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
            chk("rst_memreq_val", 128'(memreq_val), 128'(0));
            tick();
            reset = 1'b0;
            #1;
            chk("post_rst_resp_val", 128'({resp1_val, resp0_val}), 128'(0));
            chk("post_rst_memreq_val", 128'(memreq_val), 128'(0));
            chk("post_rst_req_rdy", 128'({req1_rdy, req0_rdy}), 128'(0));
            chk("post_rst_resp_dom", 128'({resp1_domain, resp0_domain}), 128'(0));
            tick();
            memresp_val = 1'b0;
            m_ptr = 1'b0;
        end else if (kind == 2) begin
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
            begin
                int  n;
                bit  seen;
                n = 0; seen = 0;
                memresp_val = 1'b0; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
                while (!seen && n < 400) begin
                    #1;
                    if (timeout_err === 1'b1) seen = 1;
                    else tick();
                    n++;
                end
                chk("to_pulse_seen", 128'(seen), 128'(1));
                chk("to_not_early", 128'(n >= 250), 128'(1));
                tick();
                chk("to_one_cycle", 128'(timeout_err), 128'(0));
                chk("to_idle_memresp_rdy", 128'(memresp_rdy), 128'(1));
                req0_val = 1'b0; req1_val = 1'b0;
                memresp_msg = rmsg; memresp_val = 1'b1;
                #1;
                chk("late_resp_dropped", 128'({resp1_val, resp0_val}), 128'(0));
                chk("late_no_memreq", 128'(memreq_val), 128'(0));
                tick();
                memresp_val = 1'b0;
                m_ptr = ~w;
            end
`endif
        end else begin
            memresp_msg = rmsg; memresp_val = 1'b1;
            for (int s = 0; s < rstall; s++) begin
                if (w) begin resp1_rdy = 1'b0; resp0_rdy = 1'($urandom); end
                else   begin resp0_rdy = 1'b0; resp1_rdy = 1'($urandom); end
                #1;
                chk("resp_val_stall", 128'({resp1_val, resp0_val}), 128'(w ? 2'b10 : 2'b01));
                chk("memresp_rdy_stall", 128'(memresp_rdy), 128'(0));
                tick();
            end
            if (w) resp1_rdy = 1'b1; else resp0_rdy = 1'b1;
            #1;
            chk("resp_val", 128'({resp1_val, resp0_val}), 128'(w ? 2'b10 : 2'b01));
            chk("resp_msg", 128'(w ? resp1_msg : resp0_msg), 128'(rmsg));
            chk("resp_dom", 128'({resp1_domain, resp0_domain}), 128'({edom, edom}));
            chk("memresp_rdy", 128'(memresp_rdy), 128'(1));
            tick();
            memresp_val = 1'b0;
            m_ptr = ~w;
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0;
        req0_msg = '0; req1_msg = '0; req0_val = 1'b1; req1_val = 1'b1;
        req0_domain = 1'b0; req1_domain = 1'b0;
        memreq_rdy = 1'b1; memresp_msg = '0; memresp_val = 1'b1;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        m_ptr = 1'b0;
        tick(); tick();
        #1;
        chk("rst_memreq_val", 128'(memreq_val), 128'(0));
        chk("rst_req_rdy", 128'({req1_rdy, req0_rdy}), 128'(0));
        chk("rst_resp_val", 128'({resp1_val, resp0_val}), 128'(0));
        chk("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
        reset = 1'b0; req0_val = 1'b0; req1_val = 1'b0; memresp_val = 1'b0;
        tick();

        // Round-robin with both requesters valid: 0,1,0,1.
        for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        // Single requester, response one cycle after issue.
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        // Lone req1 returns pointer to 0, then the secure requester beats the pointer.
        do_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0);
        do_txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0);
        // Backpressure for 5 cycles while req1 rises.
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 2, 2, 0);
        // Reset while a response is pending; pointer must return to 0.
        do_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 0, 1);
        do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
`ifdef PLAB5_MCORE_MEM_ARB_TIMEOUT_EN
        do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 2);
        do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
`endif
        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            do_txn(1'($urandom), r[0], r[1], 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
